// File: rtl/magnitude_pipe.sv
// magnitude_pipe: 4-stage valid/ready pipeline that approximates the magnitude of a signed pair.
// Mode 0 gives max(x - x/8 + y/2, x) and mode 1 gives x + y/4, where x/y are the larger/smaller of |a|,|b|.
module magnitude_pipe #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [COUNT_W-1:0] count
);

    logic v1, v2, v3, v4;
    logic adv1, adv2, adv3, adv4;
    logic accept;

    logic [WIDTH-1:0]   s1_abs_a, s1_abs_b;
    logic               s1_mode;
    logic [WIDTH-1:0]   s2_x, s2_y;
    logic               s2_mode;
    logic [WIDTH-1:0]   s3_x, s3_t1, s3_u;
    logic               s3_mode;
    logic [WIDTH-1:0]   s4_data;
    logic [COUNT_W-1:0] count_q;

    logic [WIDTH-1:0]   abs_a, abs_b, t2, s4_next;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1; a producer
    // holding valid keeps it until the transfer, and ready never depends on the same port's valid.
    assign adv4     = v4 & out_ready;
    assign adv3     = v3 & (!v4 | adv4);
    assign adv2     = v2 & (!v3 | adv3);
    assign adv1     = v1 & (!v2 | adv2);
    assign in_ready = !v1 | adv1;
    assign accept   = in_valid & in_ready;

    assign out_valid = v4;
    assign out_data  = s4_data;
    assign busy      = v1 | v2 | v3 | v4;
    assign count     = count_q;

    // The most negative input negates to 2^(WIDTH-1), which is exact as an unsigned WIDTH-bit value.
    always_comb begin
        abs_a   = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
        abs_b   = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
        t2      = s3_mode ? (s3_x + s3_u) : (s3_t1 + s3_u);
        s4_next = (t2 > s3_x) ? t2 : s3_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            v4       <= 1'b0;
            s1_abs_a <= '0;
            s1_abs_b <= '0;
            s1_mode  <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_mode  <= 1'b0;
            s3_x     <= '0;
            s3_t1    <= '0;
            s3_u     <= '0;
            s3_mode  <= 1'b0;
            s4_data  <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                v1       <= 1'b1;
                s1_abs_a <= abs_a;
                s1_abs_b <= abs_b;
                s1_mode  <= in_mode;
            end else if (adv1) begin
                v1 <= 1'b0;
            end

            if (adv1) begin
                v2      <= 1'b1;
                s2_x    <= (s1_abs_a >= s1_abs_b) ? s1_abs_a : s1_abs_b;
                s2_y    <= (s1_abs_a >= s1_abs_b) ? s1_abs_b : s1_abs_a;
                s2_mode <= s1_mode;
            end else if (adv2) begin
                v2 <= 1'b0;
            end

            if (adv2) begin
                v3      <= 1'b1;
                s3_x    <= s2_x;
                s3_t1   <= s2_x - (s2_x >> 3);
                s3_u    <= s2_mode ? (s2_y >> 2) : (s2_y >> 1);
                s3_mode <= s2_mode;
            end else if (adv3) begin
                v3 <= 1'b0;
            end

            if (adv3) begin
                v4      <= 1'b1;
                s4_data <= s4_next;
            end else if (adv4) begin
                v4 <= 1'b0;
            end

            if (adv4) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_magnitude_pipe.sv
// Self-checking bench for magnitude_pipe: directed vector table, latency/backpressure/reset
// sequences, and a randomized stream scored against an arithmetic reference model.
module tb_magnitude_pipe;

    localparam int W  = 16;
    localparam int CW = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
        logic [W-1:0] exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic [CW-1:0] count;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_out = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  drv_exp;
    logic [CW-1:0] exp_count;
    vec_t          tbl[12];

    magnitude_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .count    (count)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic m);
        int ma, mb, x, y, r;
        ma = $signed(a);
        mb = $signed(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        x = (ma > mb) ? ma : mb;
        y = (ma > mb) ? mb : ma;
        r = m ? (x + y / 4) : (x - x / 8 + y / 2);
        if (r < x) r = x;
        return W'(r);
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample both handshakes mid-cycle, then step past the rising edge.
    task automatic cycle();
        #3;
        if (in_valid && in_ready) exp_q.push_back(drv_exp);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got 0x%0h expected no result at %0t", out_data, $time);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
            exp_count = exp_count + CW'(1);
            n_out++;
        end
        @(posedge clk);
        #1;
        chk("count", W'(count), W'(exp_count));
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] e);
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        drv_exp  = e;
        in_valid = 1'b1;
    endtask

    task automatic drive_rand();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        a = rnd_val();
        b = rnd_val();
        m = 1'($urandom_range(0, 1));
        drive(a, b, m, ref_mag(a, b, m));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_q.delete();
        exp_count = '0;
    endtask

    // Single sample: out_valid must rise exactly after the 4th edge counting the accept edge.
    task automatic run_vec(input vec_t v);
        out_ready = 1'b1;
        drive(v.a, v.b, v.mode, v.exp);
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lat_early", W'(out_valid), W'(0));
            cycle();
        end
        chk("lat_valid", W'(out_valid), W'(1));
        cycle();
        chk("busy_idle", W'(busy), W'(0));
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            cycle();
            k++;
        end
        chk({name, "_drained"}, W'(exp_q.size()), W'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        tbl[0]  = '{16'h0003, 16'h0004, 1'b0, 16'd5};
        tbl[1]  = '{16'h8000, 16'h0000, 1'b0, 16'h8000};
        tbl[2]  = '{16'h8000, 16'h8000, 1'b0, 16'hB000};
        tbl[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[4]  = '{16'h0064, 16'hFFD8, 1'b0, 16'd108};
        tbl[5]  = '{16'h0064, 16'hFFD8, 1'b1, 16'd110};
        tbl[6]  = '{16'h7FFF, 16'h8000, 1'b1, 16'h9FFF};
        tbl[7]  = '{16'h7FFF, 16'h8000, 1'b0, 16'hAFFF};
        tbl[8]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0001};
        tbl[9]  = '{16'h0008, 16'h0000, 1'b0, 16'h0008};
        tbl[10] = '{16'h0000, 16'hFFF0, 1'b1, 16'h0010};
        tbl[11] = '{16'h03E8, 16'hFC18, 1'b0, 16'h055F};

        in_a = '0;
        in_b = '0;
        in_mode = 1'b0;
        out_ready = 1'b0;
        drv_exp = '0;
        exp_count = '0;
        do_reset();
        @(posedge clk);
        #1;
        do_reset();

        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_count", W'(count), W'(0));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));

        // directed vector table
        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // back-to-back, alternating mode
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(16'h0064, 16'hFFD8, 1'(i % 2), (i % 2 == 1) ? 16'd110 : 16'd108);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid", W'(out_valid), W'(1));
            cycle();
        end
        chk("b2b_idle", W'(out_valid), W'(0));

        // backpressure: 6 samples into a stalled output
        begin
            int acc;
            int out0;
            int k;
            acc = 0;
            out0 = n_out;
            out_ready = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (acc < 6) drive_rand();
                else in_valid = 1'b0;
                #1;
                chk("bp_in_ready", W'(in_ready), W'(acc < 4));
                if (out_valid && exp_q.size() != 0) chk("bp_hold", out_data, exp_q[0]);
                if (in_valid && in_ready) acc++;
                cycle();
            end
            out_ready = 1'b1;
            k = 0;
            while ((acc < 6 || exp_q.size() != 0 || busy) && k < 40) begin
                if (acc < 6) drive_rand();
                else in_valid = 1'b0;
                #1;
                if (in_valid && in_ready) acc++;
                cycle();
                k++;
            end
            in_valid = 1'b0;
            chk("bp_accepted", W'(acc), W'(6));
            chk("bp_delivered", W'(n_out - out0), W'(6));
            chk("bp_drained", W'(exp_q.size()), W'(0));
        end

        // reset with three samples in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        in_valid = 1'b0;
        chk("mid_busy", W'(busy), W'(1));
        do_reset();
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_count", W'(count), W'(0));
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        for (int i = 0; i < 6; i++) cycle();

        // randomized stream with random valid/ready (count wraps many times at CW=4)
        for (int i = 0; i < 600; i++) begin
            drive_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
